// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arb_pkg: shared types and constants for the UART TX arbiter slice.
//   arb_state_t  : controller FSM state encoding
//   NUM_REQ_DEF  : default requester count
//   DW_DEF       : default byte width
//   WDOG_CW      : watchdog counter width (WDOG_CYC must fit, i.e. <= 255)
package uart_tx_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DW_DEF      = 8;
  localparam int WDOG_CW     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ERR
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the arbiter.
//   REQ / REQ_DATA / REQ_LAST : per-requester byte offer (slice i = [i*DW +: DW])
//   REQ_ACK                   : 1-cycle per-requester launch acknowledge
//   TX_P_DATA / TX_DATA_VALID : byte and launch pulse to the UART transmitter
//   TX_BUSY                   : transmitter busy flag
//   GNT_ID / GNT_ACTIVE       : current/last owner and frame-lock status
//   WDOG_ERR                  : sticky launch watchdog error
// modport slave  : the arbiter
// modport master : requesters + transmitter (the environment)
interface uart_tx_arbiter_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DW      = DW_DEF
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    REQ;
  logic [NUM_REQ*DW-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]    REQ_LAST;
  logic [NUM_REQ-1:0]    REQ_ACK;
  logic [DW-1:0]         TX_P_DATA;
  logic                  TX_DATA_VALID;
  logic                  TX_BUSY;
  logic [IW-1:0]         GNT_ID;
  logic                  GNT_ACTIVE;
  logic                  WDOG_ERR;

  modport slave (
    input  REQ, REQ_DATA, REQ_LAST, TX_BUSY,
    output REQ_ACK, TX_P_DATA, TX_DATA_VALID, GNT_ID, GNT_ACTIVE, WDOG_ERR
  );

  modport master (
    output REQ, REQ_DATA, REQ_LAST, TX_BUSY,
    input  REQ_ACK, TX_P_DATA, TX_DATA_VALID, GNT_ID, GNT_ACTIVE, WDOG_ERR
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder.
//   req   : request vector
//   ptr   : index with highest priority; priority falls going upward with wrap
//   valid : at least one request set
//   idx   : first set request found scanning from ptr
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] sel;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = IW'((32'(ptr) + k) % NUM_REQ);
      if (!valid && req[sel]) begin
        valid = 1'b1;
        idx   = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin scheduler sharing one UART
// transmitter among NUM_REQ byte-stream requesters.
//   CLK : system clock, rising edge
//   RST : asynchronous reset, active-high
//   bus : uart_tx_arbiter_if.slave (requester offers, transmitter handshake,
//         grant status, watchdog error)
// Optional feature: define UART_TX_ARB_WDOG_EN to enable the launch watchdog
// (WDOG_CYC cycles from launch to TX_BUSY rise). Without it WAIT_BUSY waits
// indefinitely and WDOG_ERR is tied low.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int WDOG_CYC = 16
) (
  input logic              CLK,
  input logic              RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t         state;
  logic [IW-1:0]      gnt_id_q;
  logic               gnt_active_q;
  logic [IW-1:0]      rr_ptr;
  logic               last_q;
  logic [DW-1:0]      tx_p_data_q;
  logic               tx_valid_q;
  logic [NUM_REQ-1:0] req_ack_q;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [DW-1:0]      data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = bus.REQ_DATA[g*DW +: DW];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : IW'(i + 1'b1);
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.REQ),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef UART_TX_ARB_WDOG_EN
  localparam logic [WDOG_CW-1:0] WDOG_LAST = WDOG_CW'(WDOG_CYC - 1);
  logic [WDOG_CW-1:0] wdog_cnt;
  logic               wdog_err_q;
  assign bus.WDOG_ERR = wdog_err_q;
`else
  assign bus.WDOG_ERR = 1'b0;
`endif

  // The launch pulse, ack and data are registered on the edge that leaves
  // LAUNCH, so REQ_DATA/REQ_LAST are sampled during the LAUNCH cycle and the
  // pulse is seen by the transmitter in the first WAIT_BUSY cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      gnt_id_q     <= '0;
      gnt_active_q <= 1'b0;
      rr_ptr       <= '0;
      last_q       <= 1'b0;
      tx_p_data_q  <= '0;
      tx_valid_q   <= 1'b0;
      req_ack_q    <= '0;
`ifdef UART_TX_ARB_WDOG_EN
      wdog_cnt     <= '0;
      wdog_err_q   <= 1'b0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      req_ack_q  <= '0;
      case (state)
        S_IDLE: begin
          if (!bus.TX_BUSY) begin
            if (gnt_active_q) begin
              // Locked: only the owner may continue its frame.
              if (bus.REQ[gnt_id_q]) state <= S_LAUNCH;
            end else if (pick_valid) begin
              gnt_id_q     <= pick_idx;
              gnt_active_q <= 1'b1;
              state        <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          tx_p_data_q         <= data_arr[gnt_id_q];
          tx_valid_q          <= 1'b1;
          req_ack_q[gnt_id_q] <= 1'b1;
          last_q              <= bus.REQ_LAST[gnt_id_q];
`ifdef UART_TX_ARB_WDOG_EN
          wdog_cnt            <= '0;
`endif
          state               <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.TX_BUSY) begin
            state <= S_WAIT_DONE;
          end
`ifdef UART_TX_ARB_WDOG_EN
          else if (wdog_cnt == WDOG_LAST) begin
            wdog_err_q   <= 1'b1;
            gnt_active_q <= 1'b0;
            rr_ptr       <= wrap_inc(gnt_id_q);
            state        <= S_ERR;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!bus.TX_BUSY) begin
            state <= S_IDLE;
            if (last_q) begin
              gnt_active_q <= 1'b0;
              rr_ptr       <= wrap_inc(gnt_id_q);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.REQ_ACK       = req_ack_q;
  assign bus.TX_P_DATA     = tx_p_data_q;
  assign bus.TX_DATA_VALID = tx_valid_q;
  assign bus.GNT_ID        = gnt_id_q;
  assign bus.GNT_ACTIVE    = gnt_active_q;

endmodule
